// File: rtl/fp_issue_arbiter_if.sv
// Issue/writeback bundle between thread select, the issue arbiter and writeback.
// The arbiter side uses the slave modport; the thread-select/writeback side uses master.
interface fp_issue_arbiter_if #(
  parameter int NUM_THREADS = 4
);
  localparam int TW = $clog2(NUM_THREADS);

  logic [NUM_THREADS-1:0] req;
  logic [NUM_THREADS-1:0] req_is_multi_cycle;
  logic                   rollback_en;
  logic [TW-1:0]          rollback_thread;
  logic [NUM_THREADS-1:0] grant;
  logic                   wb_valid;
  logic [TW-1:0]          wb_thread;
  logic                   wb_is_multi_cycle;
  logic [NUM_THREADS-1:0] mc_busy;

  modport slave (
    input  req, req_is_multi_cycle, rollback_en, rollback_thread,
    output grant, wb_valid, wb_thread, wb_is_multi_cycle, mc_busy
  );

  modport master (
    output req, req_is_multi_cycle, rollback_en, rollback_thread,
    input  grant, wb_valid, wb_thread, wb_is_multi_cycle, mc_busy
  );
endinterface

// File: rtl/fp_issue_arbiter.sv
// Issue arbiter and writeback scheduler for the shared FP/int-multiply execute unit.
// Define FP_ISSUE_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (lowest index).
module fp_issue_arbiter #(
  parameter int NUM_THREADS = 4,
  parameter int MC_LATENCY  = 5,
  parameter int SC_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fp_issue_arbiter_if.slave     bus
);
  localparam int TW = $clog2(NUM_THREADS);

  logic [MC_LATENCY-1:0]         slot_valid_q, slot_valid_d;
  logic [MC_LATENCY-1:0]         slot_mc_q, slot_mc_d;
  logic [MC_LATENCY-1:0][TW-1:0] slot_thread_q, slot_thread_d;

  logic [NUM_THREADS-1:0] eligible;
  logic [NUM_THREADS-1:0] grant_sel;
  logic [NUM_THREADS-1:0] grant;
  logic [NUM_THREADS-1:0] mc_busy;
  logic [TW-1:0]          grant_idx;
  logic                   grant_any;
  logic                   grant_mc;

  // Slot k writes back k cycles from now; a single-cycle op lands in slot SC_LATENCY-1
  // after the shift, so it is blocked while slot SC_LATENCY is occupied today.
  for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
    logic [MC_LATENCY-1:0] hit;
    for (genvar gk = 0; gk < MC_LATENCY; gk++) begin : g_slot
      assign hit[gk] = slot_valid_q[gk] && slot_mc_q[gk] && (slot_thread_q[gk] == TW'(gi));
    end
    assign mc_busy[gi]  = |hit;
    assign eligible[gi] = bus.req[gi]
                       && !(bus.rollback_en && (bus.rollback_thread == TW'(gi)))
                       && (bus.req_is_multi_cycle[gi]
                           || (!slot_valid_q[SC_LATENCY] && !mc_busy[gi]));
  end

`ifdef FP_ISSUE_ROUND_ROBIN_EN
  logic [TW-1:0] last_grant_q, last_grant_d;
  logic [TW-1:0] rr_idx;
  logic          rr_found;

  always_comb begin
    grant_sel = '0;
    rr_idx    = '0;
    rr_found  = 1'b0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      rr_idx = last_grant_q + TW'(i);
      if (!rr_found && eligible[rr_idx]) begin
        grant_sel[rr_idx] = 1'b1;
        rr_found          = 1'b1;
      end
    end
  end

  assign last_grant_d = grant_any ? grant_idx : last_grant_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= '1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign grant_sel = eligible & (~eligible + NUM_THREADS'(1));
`endif

  assign grant     = reset_n ? grant_sel : '0;
  assign grant_any = |grant;
  assign grant_mc  = |(grant & bus.req_is_multi_cycle);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (grant[i]) grant_idx = TW'(i);
    end
  end

  always_comb begin
    slot_valid_d  = '0;
    slot_mc_d     = '0;
    slot_thread_d = '0;
    for (int k = 0; k < MC_LATENCY - 1; k++) begin
      slot_valid_d[k]  = slot_valid_q[k+1];
      slot_mc_d[k]     = slot_mc_q[k+1];
      slot_thread_d[k] = slot_thread_q[k+1];
    end
    if (grant_any) begin
      if (grant_mc) begin
        slot_valid_d[MC_LATENCY-1]  = 1'b1;
        slot_mc_d[MC_LATENCY-1]     = 1'b1;
        slot_thread_d[MC_LATENCY-1] = grant_idx;
      end else begin
        slot_valid_d[SC_LATENCY-1]  = 1'b1;
        slot_mc_d[SC_LATENCY-1]     = 1'b0;
        slot_thread_d[SC_LATENCY-1] = grant_idx;
      end
    end
    // The rolled-back thread is masked from grant, so clearing after insertion is safe.
    if (bus.rollback_en) begin
      for (int k = 0; k < MC_LATENCY; k++) begin
        if (slot_thread_d[k] == bus.rollback_thread) slot_valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q  <= '0;
      slot_mc_q     <= '0;
      slot_thread_q <= '0;
    end else begin
      slot_valid_q  <= slot_valid_d;
      slot_mc_q     <= slot_mc_d;
      slot_thread_q <= slot_thread_d;
    end
  end

  assign bus.grant             = grant;
  assign bus.mc_busy           = mc_busy;
  assign bus.wb_valid          = slot_valid_q[0];
  assign bus.wb_thread         = slot_thread_q[0];
  assign bus.wb_is_multi_cycle = slot_mc_q[0];
endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Scoreboard bench for fp_issue_arbiter: directed per-cycle vectors feed expected queues,
// a negedge monitor pops and compares.
module tb_fp_issue_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fp_issue_arbiter_if #(.NUM_THREADS(4)) bus ();

  fp_issue_arbiter #(.NUM_THREADS(4), .MC_LATENCY(5), .SC_LATENCY(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] grant;
    logic [3:0] busy;
    logic       wbv;
  } cyc_t;

  typedef struct {
    logic [1:0] thread;
    logic       mc;
  } wb_t;

  cyc_t exp_cyc[$];
  wb_t  exp_wb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cycle %0d): got %0h required %0h", name, cyc_no, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc_t c;
    wb_t  w;
    if (exp_cyc.size() > 0) begin
      c = exp_cyc.pop_front();
      chk("grant", 32'(bus.grant), 32'(c.grant));
      chk("mc_busy", 32'(bus.mc_busy), 32'(c.busy));
      chk("wb_valid", 32'(bus.wb_valid), 32'(c.wbv));
    end
    if (bus.wb_valid === 1'b1) begin
      if (exp_wb.size() == 0) begin
        chk("wb_unexpected", 32'(bus.wb_thread), 32'hFFFF);
      end else begin
        w = exp_wb.pop_front();
        $display("wb: thread %0d mc %0d (expected thread %0d mc %0d)",
                 bus.wb_thread, bus.wb_is_multi_cycle, w.thread, w.mc);
        chk("wb_thread", 32'(bus.wb_thread), 32'(w.thread));
        chk("wb_is_multi_cycle", 32'(bus.wb_is_multi_cycle), 32'(w.mc));
      end
    end
  end

  // One cycle of stimulus: inputs applied just after the edge, expectation queued.
  task automatic step(input logic [3:0] req, input logic [3:0] mc,
                      input logic rb_en, input logic [1:0] rb_thr,
                      input logic [3:0] eg, input logic [3:0] eb, input logic ewbv);
    cyc_t c;
    @(posedge clk);
    #1;
    cyc_no++;
    bus.req                = req;
    bus.req_is_multi_cycle = mc;
    bus.rollback_en        = rb_en;
    bus.rollback_thread    = rb_thr;
    c.grant = eg;
    c.busy  = eb;
    c.wbv   = ewbv;
    exp_cyc.push_back(c);
  endtask

  task automatic push_wb(input logic [1:0] thr, input logic mc);
    wb_t w;
    w.thread = thr;
    w.mc     = mc;
    exp_wb.push_back(w);
  endtask

  task automatic idle(input logic [3:0] eb, input logic ewbv);
    step(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, eb, ewbv);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  initial begin
    cyc_t c;
    logic [3:0] rr_exp [5];
    int wait_cycles;

    // Reset held with all threads requesting.
    #1;
    bus.req                = 4'b1111;
    bus.req_is_multi_cycle = 4'b0000;
    bus.rollback_en        = 1'b0;
    bus.rollback_thread    = 2'd0;
    c.grant = 4'b0000; c.busy = 4'b0000; c.wbv = 1'b0;
    exp_cyc.push_back(c);
    @(negedge clk);
    @(negedge clk);
    bus.req = 4'b0000;
    reset_n = 1'b1;

    // All threads request single-cycle ops continuously.
`ifdef FP_ISSUE_ROUND_ROBIN_EN
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
`else
    for (int i = 0; i < 5; i++) rr_exp[i] = 4'b0001;
`endif
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0000, 1'b0, 2'd0, rr_exp[i], 4'b0000, (i != 0));
      for (int t = 0; t < 4; t++) if (rr_exp[i][t]) push_wb(2'(t), 1'b0);
    end
    idle(4'b0000, 1'b1);
    idle(4'b0000, 1'b0);

    // Lone multi-cycle op on thread 1.
    step(4'b0010, 4'b0010, 1'b0, 2'd0, 4'b0010, 4'b0000, 1'b0);
    push_wb(2'd1, 1'b1);
    for (int i = 1; i <= 4; i++) idle(4'b0010, 1'b0);
    idle(4'b0010, 1'b1);
    idle(4'b0000, 1'b0);

    // Writeback port conflict: thread 0 multi-cycle, thread 2 single-cycle later.
    step(4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0001, 4'b0000, 1'b0);
    push_wb(2'd0, 1'b1);
    for (int i = 1; i <= 3; i++) idle(4'b0001, 1'b0);
    step(4'b0100, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b0);
    step(4'b0100, 4'b0000, 1'b0, 2'd0, 4'b0100, 4'b0001, 1'b1);
    push_wb(2'd2, 1'b0);
    idle(4'b0000, 1'b1);
    idle(4'b0000, 1'b0);

    // Rollback of thread 3; its own multi-cycle request is masked in the rollback cycle.
    step(4'b1000, 4'b1000, 1'b0, 2'd0, 4'b1000, 4'b0000, 1'b0);
    idle(4'b1000, 1'b0);
    step(4'b1000, 4'b1000, 1'b1, 2'd3, 4'b0000, 4'b1000, 1'b0);
    for (int i = 3; i <= 7; i++) idle(4'b0000, 1'b0);

    // Per-thread in-order completion: thread 1 single-cycle waits behind its multi-cycle op.
    step(4'b0010, 4'b0010, 1'b0, 2'd0, 4'b0010, 4'b0000, 1'b0);
    push_wb(2'd1, 1'b1);
    for (int i = 1; i <= 4; i++) step(4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0010, 1'b0);
    step(4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0010, 1'b1);
    step(4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0010, 4'b0000, 1'b0);
    push_wb(2'd1, 1'b0);
    idle(4'b0000, 1'b1);
    idle(4'b0000, 1'b0);
    idle(4'b0000, 1'b0);

    wait_cycles = 0;
    while ((exp_cyc.size() > 0 || exp_wb.size() > 0) && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(posedge clk);
    chk("pending_cycle_expectations", 32'(exp_cyc.size()), 32'd0);
    chk("pending_wb_expectations", 32'(exp_wb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_issue_arbiter.md
# fp_issue_arbiter

Issue arbiter and writeback scheduler for the shared floating-point/integer-multiply execute resource. Each cycle it grants at most one thread's ready instruction, choosing between the single-cycle path and the multi-cycle pipeline. It tracks in-flight operations in a writeback reservation shift register, so single-cycle and multi-cycle results never collide on the shared writeback port. It sits between the thread select stage and the execute pipelines, and drives writeback ownership to the writeback stage.

## Interface
- NUM_THREADS, 4: hardware threads competing for issue; a power of two ≥ 2.
- MC_LATENCY, 5: cycles from a multi-cycle grant to its writeback cycle.
- SC_LATENCY, 1: cycles from a single-cycle grant to its writeback cycle; must satisfy 1 ≤ SC_LATENCY < MC_LATENCY.

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_THREADS  thread t has an instruction ready to issue.
- req_is_multi_cycle  in  NUM_THREADS  the ready instruction of thread t is a multi-cycle op (fmul, imul, fadd family, ftoi, itof, compare).
- rollback_en  in  1  squash all in-flight ops of rollback_thread.
- rollback_thread  in  $clog2(NUM_THREADS)  thread being rolled back.
- grant  out  NUM_THREADS  one-hot or zero; combinational; the op issues at the next edge.
- wb_valid  out  1  a live result owns the writeback port this cycle.
- wb_thread  out  $clog2(NUM_THREADS)  owner of the writeback port.
- wb_is_multi_cycle  out  1  the writeback comes from the multi-cycle pipeline.
- mc_busy  out  NUM_THREADS  thread t has a live multi-cycle op in flight.

## Operation
- State: reservation slots 0..MC_LATENCY-1, each holding {valid, thread, is_mc}, plus a round-robin pointer `last_grant`.
  - Slot k means "writes back k cycles after the current one".
  - wb_* outputs come straight from slot 0.
- Each edge, slot k takes the old contents of slot k+1, and slot MC_LATENCY-1 loads invalid.
- On a grant, a new entry is written after the shift:
  - multi-cycle grant: entry goes to slot MC_LATENCY-1;
  - single-cycle grant: entry goes to slot SC_LATENCY-1.
- Eligibility of thread t in the current cycle:
  - req[t] is high, and
  - not (rollback_en && rollback_thread == t), and
  - if the op is single-cycle: slot[SC_LATENCY].valid == 0 (the writeback slot is free) and mc_busy[t] == 0 (per-thread in-order completion).
  - Multi-cycle ops are always eligible on slot grounds, because slot MC_LATENCY never exists.
- Selection: the first eligible thread searching upward from last_grant+1, modulo NUM_THREADS. last_grant updates only on a grant.
- Rollback: at the edge where rollback_en is high, every entry whose thread matches rollback_thread has valid cleared, after the shift. A freed slot may be reused by later grants.
- mc_busy[t] is the OR over slots of (valid && is_mc && thread == t). It is combinational from state.

## Timing
- Grant is combinational from req, rollback inputs and registered state; the path has no flop.
- Writeback timing: a grant in cycle n gives wb_valid in cycle n+MC_LATENCY (multi-cycle) or n+SC_LATENCY (single-cycle).
- mc_busy[t] is high from cycle n+1 through n+MC_LATENCY inclusive.
- Reset values: all slots invalid; wb_valid=0, wb_thread=0, wb_is_multi_cycle=0, mc_busy=0, grant=0 while held in reset; last_grant=NUM_THREADS-1, so thread 0 wins first.
- Reset asserted mid-operation drops all in-flight reservations immediately and asynchronously.
- Simultaneous events:
  - rollback and shift in the same edge: the shift is applied first, then the clear;
  - rollback of thread t masks t's grant in that same cycle;
  - wb_valid for a squashed entry is never asserted.
- No request: grant=0 and the pointer holds.

## Configuration
- FP_ISSUE_ROUND_ROBIN_EN defined: round-robin selection as described.
- Not defined: fixed priority, lowest eligible thread index wins. last_grant is removed; all other behaviour is identical.

## Test plan
- Reset: hold reset_n low with req=4'b1111 → grant=0, wb_valid=0, mc_busy=0. After release, with all threads requesting single-cycle ops, the first grant is 4'b0001.
- Lone multi-cycle op: thread 1 issues a multi-cycle request in cycle 0 → grant=4'b0010 in cycle 0; mc_busy[1]=1 in cycles 1–5; wb_valid=1, wb_thread=1, wb_is_multi_cycle=1 only in cycle 5.
- Port conflict: thread 0 is granted a multi-cycle op in cycle 0; thread 2 requests a single-cycle op from cycle 4 → no grant in cycle 4; grant=4'b0100 in cycle 5; wb thread 0 in cycle 5, wb thread 2 in cycle 6.
- Round robin: all four threads request single-cycle ops continuously from cycle 0 → grants 0,1,2,3,0 in cycles 0–4. With the macro undefined, grant=4'b0001 every cycle.
- Rollback: thread 3 is granted a multi-cycle op in cycle 0; rollback_en=1 with rollback_thread=3 in cycle 2 → mc_busy[3] falls in cycle 3; wb_valid stays 0 in cycle 5.
- In-order per thread: thread 1 is granted a multi-cycle op in cycle 0 and requests a single-cycle op from cycle 1 → single-cycle op blocked through cycle 5, granted in cycle 6, wb in cycle 7.
